// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//   Shares the single lookup port of the cache simulation model between
//   NUM_REQ trace requesters. Arbitration is round-robin. Only one lookup is
//   outstanding at a time. Hits and misses are counted per requester. A
//   watchdog flags a cache port that never answers.
//
// Ports
//   clk_41, rst_41         clock (rising edge); async active-high reset
//   req_valid_41/addr_41   per-requester request and address (flattened)
//   req_ready_41           one-hot accept strobe (IDLE only)
//   cache_valid_41/addr_41 lookup request to the cache model
//   cache_ready_41         cache model accepts the lookup
//   cache_rsp_valid_41/hit lookup result from the cache model
//   done_valid/id/hit_41   one-cycle completion pulse with requester index
//   hits_41 / misses_41    per-requester saturating counters (flattened)
//   timeout_err_41         sticky watchdog error
//   dbg_state_41           current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The requester holds valid/address stable until it sees ready. The
// arbiter holds cache_valid/addr stable until cache_ready is seen.
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 31,
  parameter int CNT_W   = 31,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk_41,
  input  logic                        rst_41,
  input  logic [NUM_REQ-1:0]          req_valid_41,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_41,
  output logic [NUM_REQ-1:0]          req_ready_41,
  output logic                        cache_valid_41,
  output logic [ADDR_W-1:0]           cache_addr_41,
  input  logic                        cache_ready_41,
  input  logic                        cache_rsp_valid_41,
  input  logic                        cache_rsp_hit_41,
  output logic                        done_valid_41,
  output logic [$clog2(NUM_REQ)-1:0]  done_id_41,
  output logic                        done_hit_41,
  output logic [NUM_REQ*CNT_W-1:0]    hits_41,
  output logic [NUM_REQ*CNT_W-1:0]    misses_41,
  output logic                        timeout_err_41,
  output logic [1:0]                  dbg_state_41
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                done_valid_q, done_valid_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic                done_hit_q, done_hit_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]    hits_q   [NUM_REQ];
  logic [CNT_W-1:0]    hits_d   [NUM_REQ];
  logic [CNT_W-1:0]    misses_q [NUM_REQ];
  logic [CNT_W-1:0]    misses_d [NUM_REQ];

  logic                grant_found;
  int unsigned         grant_idx;

  // Round-robin pick: first valid requester after the last winner, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int unsigned cand;
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid_41[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    wdog_d        = wdog_q;
    done_valid_d  = 1'b0;
    done_id_d     = done_id_q;
    done_hit_d    = done_hit_q;
    timeout_err_d = timeout_err_q;
    hits_d        = hits_q;
    misses_d      = misses_q;
    req_ready_41  = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          // Accept strobe is combinational so the requester sees it in the
          // same cycle the address is captured.
          req_ready_41[grant_idx] = 1'b1;
          id_d          = ID_W'(grant_idx);
          rr_ptr_d      = ID_W'(grant_idx);
          cache_addr_d  = req_addr_41[grant_idx*ADDR_W +: ADDR_W];
          cache_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cache_ready_41) begin
          cache_valid_d = 1'b0;
          wdog_d        = '0;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the expiry cycle still counts as a normal response.
        if (cache_rsp_valid_41) begin
          if (cache_rsp_hit_41) begin
            if (hits_q[id_q] != {CNT_W{1'b1}}) hits_d[id_q] = hits_q[id_q] + CNT_W'(1);
          end else begin
            if (misses_q[id_q] != {CNT_W{1'b1}}) misses_d[id_q] = misses_q[id_q] + CNT_W'(1);
          end
          done_valid_d = 1'b1;
          done_id_d    = id_q;
          done_hit_d   = cache_rsp_hit_41;
          state_d      = S_IDLE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          done_valid_d  = 1'b1;
          done_id_d     = id_q;
          done_hit_d    = 1'b0;
          state_d       = S_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      wdog_q        <= '0;
      done_valid_q  <= 1'b0;
      done_id_q     <= '0;
      done_hit_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hits_q[i]   <= '0;
        misses_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      wdog_q        <= wdog_d;
      done_valid_q  <= done_valid_d;
      done_id_q     <= done_id_d;
      done_hit_q    <= done_hit_d;
      timeout_err_q <= timeout_err_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        hits_q[i]   <= hits_d[i];
        misses_q[i] <= misses_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign hits_41[g*CNT_W +: CNT_W]   = hits_q[g];
    assign misses_41[g*CNT_W +: CNT_W] = misses_q[g];
  end

  assign cache_valid_41 = cache_valid_q;
  assign cache_addr_41  = cache_addr_q;
  assign done_valid_41  = done_valid_q;
  assign done_id_41     = done_id_q;
  assign done_hit_41    = done_hit_q;
  assign timeout_err_41 = timeout_err_q;
  assign dbg_state_41   = state_q;

endmodule
